wb_arbiter: RTL
===============

# wb_arbiter

Writeback arbiter sitting directly upstream of the 64-bit, 32-entry register file; drives its single write port (`rd_write`, `rd_addr`, `rd_data`). Merges single-cycle ALU results with long-latency memory/mul-div results, which arrive through a 2-entry buffer. Keeps write-after-write order when a younger ALU result targets the same register as a buffered older result. Exports a pending-destination mask for issue-stage hazard checks.

## Interface
Parameters:
- `XLEN`, 64, datapath width
- `DEPTH`, 2, memory-result buffer entries (power of two, ≥2)

Ports:
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  synchronous, active-low reset (0 = reset)
- `alu_valid`  in  1  ALU result present
- `alu_ready`  out  1  ALU result accepted this cycle
- `alu_rd`  in  5  ALU destination
- `alu_data`  in  XLEN  ALU result
- `mem_valid`  in  1  memory/long-latency result present
- `mem_ready`  out  1  buffer can accept
- `mem_rd`  in  5  memory destination
- `mem_data`  in  XLEN  memory result
- `rd_write`  out  1  register-file write enable (registered)
- `rd_addr`  out  5  register-file write address (registered)
- `rd_data`  out  XLEN  register-file write data (registered)
- `pend_mask`  out  32  bit r set = live buffered write to xr pending
- `wb_count`  out  32  number of `rd_write` pulses since reset, wraps

## Operation
- Handshake: transfer when valid && ready on a clock edge. Sources hold payload while valid && !ready.
- `mem_ready` = (occupancy < DEPTH) and not in reset. Accepted memory results are enqueued with `killed`=0.
- Selection each cycle, in priority order:
  1. Buffer full and head live: head issues; `alu_ready`=0.
  2. `alu_valid`: ALU issues; `alu_ready`=1.
  3. Buffer non-empty and head live: head issues.
- When not full, `alu_ready`=1.
- Killed head: popped in any cycle without issuing. It does not block the ALU or a live issue. At most one pop per cycle.
- Issue with rd = 0: no `rd_write`. The entry is still consumed or accepted.
- WAW kill: an ALU result accepted with rd ≠ 0 sets `killed` on every live buffer entry with the same rd. This includes a memory result enqueued in the same cycle, which is defined as older.
- `pend_mask`: OR of one-hot(rd) over live, non-killed buffer entries. Bit 0 is always 0. Combinational from buffer state.
- `wb_count` increments on each cycle where `rd_write` = 1.

## Timing
- ALU accepted in cycle N → `rd_write` = 1 in cycle N+1.
- Memory accepted in cycle N → earliest issue N+1, earliest `rd_write` N+2. No bypass.
- Output register updates every cycle. `rd_write` = 0 when nothing issued.
- Full buffer: `mem_ready` = 0. No simultaneous enqueue and dequeue at full. A dequeue frees the slot from the next cycle.
- Reset (`rst` = 0 at an edge), including mid-operation:
  - buffer flushed, in-flight entries discarded
  - `rd_write` = 0, `rd_addr` = 0, `rd_data` = 0, `wb_count` = 0, `pend_mask` = 0
  - `mem_ready` = 0 and `alu_ready` = 0 while `rst` = 0; both 1 on the first cycle after release

## Structure
- Shared `riscv_pkg`:
  - `XLEN`
  - `REG_ADDR_W` = 5
  - `NUM_REGS` = 32
  - `wb_entry_t` struct {`rd`, `data`, `killed`}
- Sub-module `wb_fifo`:
  - circular buffer of `wb_entry_t`, pointer width $clog2(DEPTH)+1
  - enqueue/dequeue ports
  - kill-by-rd input
  - per-entry valid/rd view for `pend_mask`
- Arbitration, output register and counter live in `wb_arbiter`.

## Test plan
- ALU only: `alu_valid` with rd=5, data=0x1234 → next cycle `rd_write`=1, `rd_addr`=5, `rd_data`=0x1234; `wb_count`=1.
- Memory only: rd=7, data=0xDEAD accepted in cycle N → `pend_mask`[7]=1 in N+1, `rd_write` in N+2; `pend_mask` clears once popped.
- Back-pressure: two memory results accepted with `alu_valid` held high → `mem_ready`=0; head issues and `alu_ready`=0 that cycle; ALU result written the following cycle.
- WAW: memory rd=3 buffered, then ALU rd=3 data=0xA → only 0xA written to x3; killed entry popped silently; `wb_count`=1.
- rd=0 from either source → no `rd_write`, entry consumed, `wb_count` unchanged.
- Reset with 2 entries buffered → next cycle all outputs 0, `pend_mask`=0; after release `mem_ready`=1 and no stale write appears.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared core types for the writeback path: register-file geometry and the
// buffered writeback entry.
package riscv_pkg;
  localparam int XLEN       = 64;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
    logic                  killed;  // superseded by a younger ALU write
  } wb_entry_t;
endpackage

// File: rtl/wb_arbiter_if.sv
// Writeback arbiter bus: ALU and memory result handshakes in, register-file
// write port and hazard/status outputs out.
interface wb_arbiter_if #(
  parameter int XLEN = 64
);
  import riscv_pkg::*;

  logic                  alu_valid;
  logic                  alu_ready;
  logic [REG_ADDR_W-1:0] alu_rd;
  logic [XLEN-1:0]       alu_data;
  logic                  mem_valid;
  logic                  mem_ready;
  logic [REG_ADDR_W-1:0] mem_rd;
  logic [XLEN-1:0]       mem_data;
  logic                  rd_write;
  logic [REG_ADDR_W-1:0] rd_addr;
  logic [XLEN-1:0]       rd_data;
  logic [NUM_REGS-1:0]   pend_mask;
  logic [31:0]           wb_count;

  // arbiter side
  modport slave (
    input  alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
    output alu_ready, mem_ready, rd_write, rd_addr, rd_data, pend_mask, wb_count
  );

  // producer / register-file side
  modport master (
    output alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
    input  alu_ready, mem_ready, rd_write, rd_addr, rd_data, pend_mask, wb_count
  );
endinterface

// File: rtl/wb_fifo.sv
// Circular buffer of long-latency writeback entries. Supports marking every
// live entry with a given rd as killed, and exposes a per-slot live/rd view.
module wb_fifo
  import riscv_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             enq,
  input  wb_entry_t                        enq_entry,
  input  logic                             deq,
  input  logic                             kill_en,
  input  logic [REG_ADDR_W-1:0]            kill_rd,
  output wb_entry_t                        head,
  output logic                             empty,
  output logic                             full,
  output logic [DEPTH-1:0]                 ent_live,
  output logic [DEPTH-1:0][REG_ADDR_W-1:0] ent_rd
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  wb_entry_t         mem [DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr, count;
  logic [DEPTH-1:0]  slot_vld;
  wb_entry_t         enq_w;

  assign count = wr_ptr - rd_ptr;
  assign empty = (count == '0);
  assign full  = (count == PW'(DEPTH));
  assign head  = mem[rd_ptr[AW-1:0]];

  // A result enqueued alongside a matching ALU write is the older one: kill it on entry.
  always_comb begin
    enq_w        = enq_entry;
    enq_w.killed = enq_entry.killed | (kill_en && (kill_rd == enq_entry.rd));
  end

  // Per-slot occupancy: slot is live when its distance from head is below count.
  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    logic [AW-1:0] offs;
    assign offs        = AW'(i) - rd_ptr[AW-1:0];
    assign slot_vld[i] = ({1'b0, offs} < count);
    assign ent_live[i] = slot_vld[i] & ~mem[i].killed;
    assign ent_rd[i]   = mem[i].rd;
  end

  // Pointer update; reset flushes everything in flight.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + 1'b1;
      if (deq) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Entry storage: write on enqueue, otherwise apply WAW kill to matching live slots.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (enq && (AW'(i) == wr_ptr[AW-1:0]))
        mem[i] <= enq_w;
      else if (kill_en && slot_vld[i] && (mem[i].rd == kill_rd))
        mem[i].killed <= 1'b1;
    end
  end
endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges single-cycle ALU results with buffered
// long-latency results onto the register-file write port, preserving
// write-after-write order and exporting a pending-destination mask.
module wb_arbiter #(
  parameter int XLEN  = 64,
  parameter int DEPTH = 2
) (
  input logic         clk,
  input logic         rst,
  wb_arbiter_if.slave bus
);
  import riscv_pkg::*;

  wb_entry_t                        head, enq_w;
  logic                             empty, full;
  logic [DEPTH-1:0]                 ent_live;
  logic [DEPTH-1:0][REG_ADDR_W-1:0] ent_rd;

  logic                  head_live, issue_head, issue_alu, pop, enq, kill_en;
  logic                  nxt_write;
  logic [REG_ADDR_W-1:0] nxt_addr;
  logic [XLEN-1:0]       nxt_data;
  logic                  rd_write_q;
  logic [REG_ADDR_W-1:0] rd_addr_q;
  logic [XLEN-1:0]       rd_data_q;
  logic [31:0]           wb_count_q;
  logic [NUM_REGS-1:0]   pm;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .enq       (enq),
    .enq_entry (enq_w),
    .deq       (pop),
    .kill_en   (kill_en),
    .kill_rd   (bus.alu_rd),
    .head      (head),
    .empty     (empty),
    .full      (full),
    .ent_live  (ent_live),
    .ent_rd    (ent_rd)
  );

  // Arbitration: full buffer drains first, then ALU, then buffer; killed heads drop silently.
  always_comb begin
    head_live     = !empty && !head.killed;
    bus.mem_ready = rst && !full;
    bus.alu_ready = rst && !(full && head_live);
    issue_head    = 1'b0;
    issue_alu     = 1'b0;
    if (rst) begin
      if (full && head_live)  issue_head = 1'b1;
      else if (bus.alu_valid) issue_alu  = 1'b1;
      else if (head_live)     issue_head = 1'b1;
    end
    pop     = rst && !empty && (head.killed || issue_head);
    enq     = bus.mem_valid && bus.mem_ready;
    kill_en = issue_alu && (bus.alu_rd != '0);
    enq_w   = '{rd: bus.mem_rd, data: bus.mem_data, killed: 1'b0};

    nxt_write = 1'b0;
    nxt_addr  = '0;
    nxt_data  = '0;
    if (issue_alu) begin
      nxt_write = (bus.alu_rd != '0);
      nxt_addr  = bus.alu_rd;
      nxt_data  = bus.alu_data;
    end else if (issue_head) begin
      nxt_write = (head.rd != '0);
      nxt_addr  = head.rd;
      nxt_data  = head.data;
    end
  end

  // Registered write port and write-pulse counter; counter moves with rd_write.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_write_q <= 1'b0;
      rd_addr_q  <= '0;
      rd_data_q  <= '0;
      wb_count_q <= '0;
    end else begin
      rd_write_q <= nxt_write;
      rd_addr_q  <= nxt_addr;
      rd_data_q  <= nxt_data;
      wb_count_q <= wb_count_q + {31'd0, nxt_write};
    end
  end

  // Pending destinations from live, unkilled entries; x0 never pends.
  always_comb begin
    pm = '0;
    for (int i = 0; i < DEPTH; i++)
      if (ent_live[i]) pm[ent_rd[i]] = 1'b1;
    pm[0] = 1'b0;
  end

  assign bus.rd_write  = rd_write_q;
  assign bus.rd_addr   = rd_addr_q;
  assign bus.rd_data   = rd_data_q;
  assign bus.wb_count  = wb_count_q;
  assign bus.pend_mask = pm;
endmodule
